// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: leader, addr, ~addr, cmd, ~cmd, stop mark, then an idle gap.
// Optional repeat-code support is enabled with `define NEC_IR_TX_REPEAT_EN.
module nec_ir_tx #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 72
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
`ifdef NEC_IR_TX_REPEAT_EN
  input  logic       tx_repeat,
`endif
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int MAX_A = (UNIT_CYCLES > 2 * CARRIER_HALF) ? UNIT_CYCLES : 2 * CARRIER_HALF;
  localparam int MAX_B = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] UNIT_LAST   = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CARR_LAST   = CW'(2 * CARRIER_HALF - 1);
  localparam logic [CW-1:0] CARR_HALF_V = CW'(CARRIER_HALF);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
`ifdef NEC_IR_TX_REPEAT_EN
    , REP_SPACE = 3'd7
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] unit_q, unit_d;
  logic [CW-1:0] units_q, units_d;
  logic [CW-1:0] carr_q, carr_d;
  logic [5:0]    bit_q, bit_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          tx_ready_q, tx_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ir_env_q, ir_env_d;
  logic          ir_out_q, ir_out_d;
`ifdef NEC_IR_TX_REPEAT_EN
  logic          rep_q, rep_d;
`endif

  logic          unit_tick_s;
  logic          state_end_s;
  logic [CW-1:0] seg_units_s;

  function automatic logic [CW-1:0] seg_units(input state_t s, input logic cur_bit);
    case (s)
      LEAD_MARK:  return CW'(16);
      LEAD_SPACE: return CW'(8);
      BIT_MARK:   return CW'(1);
      BIT_SPACE:  return cur_bit ? CW'(3) : CW'(1);
      STOP_MARK:  return CW'(1);
      GAP:        return CW'(GAP_UNITS);
`ifdef NEC_IR_TX_REPEAT_EN
      REP_SPACE:  return CW'(4);
`endif
      default:    return CW'(1);
    endcase
  endfunction

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

  // Next-state, counters and the registered-output precomputation.
  always_comb begin
    state_d     = state_q;
    unit_d      = unit_q;
    units_d     = units_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
`ifdef NEC_IR_TX_REPEAT_EN
    rep_d       = rep_q;
`endif
    seg_units_s = seg_units(state_q, shreg_q[0]);
    unit_tick_s = (unit_q == UNIT_LAST);
    state_end_s = unit_tick_s && (units_q == seg_units_s - CW'(1));

    if (state_q == IDLE) begin
      unit_d  = {CW{1'b0}};
      units_d = {CW{1'b0}};
      bit_d   = 6'd0;
      if (tx_valid && tx_ready_q) begin
        state_d = LEAD_MARK;
        shreg_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
`ifdef NEC_IR_TX_REPEAT_EN
        rep_d   = tx_repeat;
`endif
      end else begin
        state_d = IDLE;
      end
    end else begin
      unit_d = unit_tick_s ? {CW{1'b0}} : unit_q + CW'(1);
      if (state_end_s) begin
        units_d = {CW{1'b0}};
      end else if (unit_tick_s) begin
        units_d = units_q + CW'(1);
      end else begin
        units_d = units_q;
      end

      if (state_end_s) begin
        case (state_q)
          LEAD_MARK: begin
`ifdef NEC_IR_TX_REPEAT_EN
            state_d = rep_q ? REP_SPACE : LEAD_SPACE;
`else
            state_d = LEAD_SPACE;
`endif
          end
          LEAD_SPACE: state_d = BIT_MARK;
          BIT_MARK:   state_d = BIT_SPACE;
          BIT_SPACE: begin
            shreg_d = {1'b0, shreg_q[31:1]};
            if (bit_q == 6'd31) begin
              state_d = STOP_MARK;
            end else begin
              bit_d   = bit_q + 6'd1;
              state_d = BIT_MARK;
            end
          end
`ifdef NEC_IR_TX_REPEAT_EN
          REP_SPACE:  state_d = STOP_MARK;
`endif
          STOP_MARK:  state_d = GAP;
          GAP:        state_d = IDLE;
          default:    state_d = IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end

    // Carrier phase restarts on every mark entry so each mark begins with a high half-period.
    ir_env_d = is_mark(state_d);
    if (!ir_env_d || (state_d != state_q)) begin
      carr_d = {CW{1'b0}};
    end else if (carr_q == CARR_LAST) begin
      carr_d = {CW{1'b0}};
    end else begin
      carr_d = carr_q + CW'(1);
    end
    ir_out_d   = ir_env_d && (carr_d < CARR_HALF_V);
    done_d     = (state_d == GAP) && (state_q != GAP);
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      unit_q     <= {CW{1'b0}};
      units_q    <= {CW{1'b0}};
      carr_q     <= {CW{1'b0}};
      bit_q      <= 6'd0;
      shreg_q    <= 32'd0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ir_env_q   <= 1'b0;
      ir_out_q   <= 1'b0;
`ifdef NEC_IR_TX_REPEAT_EN
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      units_q    <= units_d;
      carr_q     <= carr_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ir_env_q   <= ir_env_d;
      ir_out_q   <= ir_out_d;
`ifdef NEC_IR_TX_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ir_env   = ir_env_q;
  assign ir_out   = ir_out_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx: per-cycle comparison against a segment-list model of the NEC frame,
// plus directed literal checks (frame timing, decoded bytes, carrier, mid-frame reset).
module tb_nec_ir_tx;
  localparam int U  = 4;
  localparam int CH = 1;
  localparam int G  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_addr = 8'd0;
  logic [7:0] tx_cmd = 8'd0;
  logic       tx_repeat = 1'b0;
  logic       tx_ready, busy, done, ir_env, ir_out;

  nec_ir_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .GAP_UNITS(G)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_cmd(tx_cmd),
`ifdef NEC_IR_TX_REPEAT_EN
    .tx_repeat(tx_repeat),
`endif
    .tx_ready(tx_ready), .busy(busy), .done(done), .ir_env(ir_env), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic env;
    logic out;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   accept_cnt = 0;
  logic exp_ready = 1'b1;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // A level held for some units; marks carry a carrier that starts high.
  task automatic push_seg(input logic lvl, input int units);
    exp_t e;
    for (int k = 0; k < units * U; k++) begin
      e.ready = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.env = lvl;
      e.out = lvl && (((k / CH) % 2) == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic build(input logic [7:0] a, input logic [7:0] c, input logic rep);
    logic [31:0] w;
    exp_t e;
    w = {~c, c, ~a, a};
    push_seg(1'b1, 16);
    if (rep) begin
      push_seg(1'b0, 4);
    end else begin
      push_seg(1'b0, 8);
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, w[i] ? 3 : 1);
      end
    end
    push_seg(1'b1, 1);
    for (int k = 0; k < G * U; k++) begin
      e.ready = 1'b0; e.busy = 1'b1; e.done = (k == 0); e.env = 1'b0; e.out = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Model: decide acceptance at each active edge.
  initial forever begin
    logic rep;
    @(posedge clk);
`ifdef NEC_IR_TX_REPEAT_EN
    rep = tx_repeat;
`else
    rep = 1'b0;
`endif
    if (reset) begin
      exp_q.delete();
    end else if (chk_en && exp_ready && tx_valid) begin
      build(tx_addr, tx_cmd, rep);
      accept_cnt++;
    end
  end

  // Compare all outputs every cycle on the falling edge.
  initial forever begin
    exp_t e, a;
    @(negedge clk);
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{ready: 1'b1, busy: 1'b0, done: 1'b0, env: 1'b0, out: 1'b0};
      exp_ready = e.ready;
      a = '{ready: tx_ready, busy: busy, done: done, env: ir_env, out: ir_out};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle t=%0t {ready,busy,done,env,out} actual=%b required=%b", $time, a, e);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] c, input logic rep, input logic hold);
    int start, n;
    start = accept_cnt; n = 0;
    tx_addr = a; tx_cmd = c; tx_repeat = rep; tx_valid = 1'b1;
    do begin
      @(posedge clk); #2; n++;
    end while (accept_cnt == start && n < 3000);
    chk("accept_bound", int'(accept_cnt != start), 1);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Watch a frame from the cycle after acceptance; decode envelope runs like a receiver.
  task automatic capture(output int done_idx, output int ready_idx, output logic [31:0] word,
                         output int lead_m, output int lead_s, output logic [3:0] lead_out);
    logic env_hist[$];
    int runs[$];
    int i, cur;
    i = 0; done_idx = -1; ready_idx = -1; word = 32'd0; lead_out = 4'd0;
    while (ready_idx < 0 && i < 3000) begin
      @(negedge clk); i++;
      if (i <= 4) lead_out = {lead_out[2:0], ir_out};
      if (done_idx < 0) begin
        env_hist.push_back(ir_env);
        if (done) done_idx = i;
      end
      if (tx_ready) ready_idx = i;
    end
    cur = 1;
    for (int k = 1; k < env_hist.size(); k++) begin
      if (env_hist[k] == env_hist[k-1]) cur++;
      else begin runs.push_back(cur); cur = 1; end
    end
    runs.push_back(cur);
    lead_m = (runs.size() > 0) ? runs[0] : -1;
    lead_s = (runs.size() > 1) ? runs[1] : -1;
    if (runs.size() >= 67)
      for (int b = 0; b < 32; b++) word[b] = (runs[3 + 2*b] > 2 * U);
  endtask

  function automatic int cycles_to_bit(input logic [31:0] w, input int bitn);
    int n;
    n = 24 * U;
    for (int i = 0; i < bitn; i++) n += (w[i] ? 4 : 2) * U;
    return n;
  endfunction

  initial begin
    int d_idx, r_idx, lm, ls, start, wait_n;
    logic [31:0] word;
    logic [3:0] lo;
    logic [7:0] ra, rc;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("idle_ready", int'(tx_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // 0x00/0x45 while 0x12/0x34 is held valid throughout the frame.
    send(8'h00, 8'h45, 1'b0, 1'b1);
    chk("model_len", exp_q.size(), 492);
    tx_addr = 8'h12; tx_cmd = 8'h34;
    capture(d_idx, r_idx, word, lm, ls, lo);
    chk("done_idx", d_idx, 485);
    chk("ready_gap", r_idx - d_idx, 8);
    chk("lead_mark", lm, 64);
    chk("lead_space", ls, 32);
    chk("lead_carrier", int'(lo), 4'b1010);
    chk("word1", int'(word), int'(32'hBA45FF00));
    start = accept_cnt;
    @(posedge clk); #2;
    chk("second_accept_immediate", accept_cnt - start, 1);
    tx_valid = 1'b0;

    // Reset in the middle of bit 10's mark of 0x12/0x34.
    wait_n = cycles_to_bit(32'hCB34ED12, 10) + 1;
    repeat (wait_n) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_env", int'(ir_env), 0);
    chk("rst_out", int'(ir_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_done", int'(done), 0);

    send(8'hAA, 8'h55, 1'b0, 1'b0);
    capture(d_idx, r_idx, word, lm, ls, lo);
    chk("word_aa55", int'(word), int'(32'hAA5555AA));
    chk("done_idx_aa55", d_idx, 485);

    // Randomised traffic with occasional mid-frame resets.
    for (int it = 0; it < 14; it++) begin
      ra = 8'($urandom); rc = 8'($urandom);
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #2;
      send(ra, rc, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 450)) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
      end else begin
        capture(d_idx, r_idx, word, lm, ls, lo);
        chk("rand_word", int'(word), int'({~rc, rc, ~ra, ra}));
      end
    end

`ifdef NEC_IR_TX_REPEAT_EN
    repeat (3) @(posedge clk);
    #2;
    send(8'h5A, 8'hC3, 1'b1, 1'b0);
    tx_repeat = 1'b0;
    capture(d_idx, r_idx, word, lm, ls, lo);
    chk("rep_done_idx", d_idx, 85);
    chk("rep_ready_gap", r_idx - d_idx, 8);
    chk("rep_lead", lm, 64);
    chk("rep_space", ls, 16);
`endif

    repeat (20) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
